// File: rtl/serial_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_io_ctrl_if
//   Groups the processor-bus side and the serial-port side of serial_io_ctrl.
//   Modport "slave" is the controller's view, modport "master" is the view of
//   whatever drives the bus and the serial port (processor / testbench).
//
//   Bus side
//     bus_addr        word select: 0=DATA 1=STATUS 2=CONTROL 3=reserved
//     bus_read        load strobe, one cycle per access
//     bus_write       store strobe, one cycle per access
//     bus_wdata       store data
//     bus_rdata       load data, combinational from bus_addr
//   Serial side
//     serial_in       inbound byte
//     serial_valid_in serial_in is valid
//     serial_rden_out RX accept
//     serial_out      TX FIFO head, 0 when TX is empty
//     serial_ready_in sink can take a byte
//     serial_wren_out TX transfer
// -----------------------------------------------------------------------------
interface serial_io_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 32
);
  logic [1:0]        bus_addr;
  logic              bus_read;
  logic              bus_write;
  logic [BUS_W-1:0]  bus_wdata;
  logic [BUS_W-1:0]  bus_rdata;
  logic [DATA_W-1:0] serial_in;
  logic              serial_valid_in;
  logic              serial_rden_out;
  logic [DATA_W-1:0] serial_out;
  logic              serial_ready_in;
  logic              serial_wren_out;

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_wdata,
    input  serial_in, serial_valid_in, serial_ready_in,
    output bus_rdata, serial_rden_out, serial_out, serial_wren_out
  );

  modport master (
    output bus_addr, bus_read, bus_write, bus_wdata,
    output serial_in, serial_valid_in, serial_ready_in,
    input  bus_rdata, serial_rden_out, serial_out, serial_wren_out
  );
endinterface

// File: rtl/serial_io_ctrl.sv
// -----------------------------------------------------------------------------
// serial_io_ctrl
//   Memory-mapped byte-serial I/O controller. Inbound bytes are buffered in an
//   RX FIFO and read through the DATA register; stores to DATA are buffered in
//   a TX FIFO and handed to the serial sink. STATUS reports FIFO levels and
//   sticky error flags; CONTROL flushes FIFOs and clears the flags.
//
//   Ports
//     clock    system clock, rising edge
//     reset    asynchronous, active-low reset
//     bus      serial_io_ctrl_if.slave (bus and serial handshake signals)
//     irq_out  interrupt request
//
//   Optional feature: define SERIAL_IRQ_EN to get registered interrupt
//   enables at CONTROL[4:3] (bit 3: RX not empty, bit 4: TX empty). Without
//   it irq_out is constant 0 and CONTROL[4:3] are ignored.
// -----------------------------------------------------------------------------
module serial_io_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BUS_W    = 32,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  serial_io_ctrl_if.slave   bus,
  output logic              irq_out
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int TCW = TAW + 1;
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RAW-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic [TAW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [RCW-1:0]    rx_count;
  logic [TCW-1:0]    tx_count;
  logic              rx_underflow, tx_overflow;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic sel_data, sel_ctrl;
  logic data_rd, data_wr, ctrl_wr;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic flush_rx, flush_tx, clear_flags;
  logic unused_wdata;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);

  // A simultaneous write turns a DATA read into a side-effect-free peek.
  assign sel_data = (bus.bus_addr == 2'd0);
  assign sel_ctrl = (bus.bus_addr == 2'd2);
  assign data_rd  = bus.bus_read & ~bus.bus_write & sel_data;
  assign data_wr  = bus.bus_write & sel_data;
  assign ctrl_wr  = bus.bus_write & sel_ctrl;

  assign flush_rx    = ctrl_wr & bus.bus_wdata[0];
  assign flush_tx    = ctrl_wr & bus.bus_wdata[1];
  assign clear_flags = ctrl_wr & bus.bus_wdata[2];

  // rx_full is taken from the registered count, so a same-cycle pop never
  // opens room for a push on a full FIFO.
  assign rx_push = bus.serial_valid_in & ~rx_full;
  assign rx_pop  = data_rd & ~rx_empty;
  assign tx_pop  = ~tx_empty & bus.serial_ready_in;
  assign tx_push = data_wr & (~tx_full | tx_pop);

  assign bus.serial_rden_out = rx_push;
  assign bus.serial_wren_out = tx_pop;
  assign bus.serial_out      = tx_empty ? '0 : tx_mem[tx_rd_ptr];

  // Only the low bits of the store data are meaningful.
  assign unused_wdata = ^bus.bus_wdata;

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.serial_in;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.bus_wdata[DATA_W-1:0];
  end

  // RX pointers and level; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (flush_rx) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RCW'(1);
        2'b01:   rx_count <= rx_count - RCW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX pointers and level; a write into a full FIFO only lands when the sink
  // drains the head in the same cycle, leaving the level unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (flush_tx) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TCW'(1);
        2'b01:   tx_count <= tx_count - TCW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else if (clear_flags) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (data_rd && rx_empty)           rx_underflow <= 1'b1;
      if (data_wr && tx_full && !tx_pop) tx_overflow  <= 1'b1;
    end
  end

`ifdef SERIAL_IRQ_EN
  logic [1:0] irq_en;
  logic       irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus.bus_wdata[4:3];
      irq_q <= (~rx_empty & irq_en[0]) | (tx_empty & irq_en[1]);
    end
  end

  assign irq_out = irq_q;
`else
  assign irq_out = 1'b0;
`endif

  always_comb begin
    bus.bus_rdata = '0;
    case (bus.bus_addr)
      2'd0: if (!rx_empty) bus.bus_rdata = BUS_W'(rx_mem[rx_rd_ptr]);
      2'd1: bus.bus_rdata = BUS_W'({8'h00, 8'(tx_count), 8'(rx_count), 2'b00,
                                     tx_overflow, rx_underflow,
                                     tx_full, tx_empty, rx_full, rx_empty});
`ifdef SERIAL_IRQ_EN
      2'd2: bus.bus_rdata = BUS_W'({irq_en, 3'b000});
`endif
      default: bus.bus_rdata = '0;
    endcase
  end

endmodule
